// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared widths, store-size encodings and grant type for mem_arbiter
// Revision : 1.0
// ============================================================================
package mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;

    localparam logic [1:0] SZ_B = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_e;

    // Encoding 00 has no size; callers treat a zero result as illegal.
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_bytes = 4'd1;
            SZ_W:    size_bytes = 4'd4;
            SZ_D:    size_bytes = 4'd8;
            default: size_bytes = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Fetch/data request ports and RAM control bundle of mem_arbiter
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              ram_load;
    logic [1:0]        ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_d;
    logic [DATA_W-1:0] ram_q;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_q,
        output if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata, d_err,
        output ram_load, ram_wr, ram_addr, ram_d
    );

    // Requester and RAM side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_q,
        input  if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata, d_err,
        input  ram_load, ram_wr, ram_addr, ram_d
    );

endinterface
`default_nettype wire

// File: rtl/mem_resp_reg.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_reg
// Brief    : Per-port response register: one-cycle valid pulse with data/err
// Revision : 1.0
// ============================================================================
module mem_resp_reg #(
    parameter int DATA_W = 64
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_gnt,
    input  wire logic [DATA_W-1:0] i_rdata,
    input  wire logic              i_err,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_rdata,
    output logic                   o_err
);

    localparam logic [0:0] RESP_IDLE = 1'b0;
    localparam logic [0:0] RESP_PEND = 1'b1;

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RESP_IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                RESP_IDLE: r_state <= i_gnt ? RESP_PEND : RESP_IDLE;
                RESP_PEND: r_state <= i_gnt ? RESP_PEND : RESP_IDLE;
                default:   r_state <= RESP_IDLE;
            endcase
            if (i_gnt) begin
                r_rdata <= i_rdata;
                r_err   <= i_err;
            end else begin
                r_err   <= 1'b0;
            end
        end
    end

    // A response still pending when reset arrives must never be seen.
    assign o_valid = (r_state == RESP_PEND) && !reset;
    assign o_rdata = reset ? '0 : r_rdata;
    assign o_err   = r_err && !reset;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin fetch/load-store arbiter and sole driver of the RAM
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);

    gnt_e              r_last_grant;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_d;

    logic              w_if_gnt;
    logic              w_d_gnt;
    logic [3:0]        w_bytes;
    logic [ADDR_W:0]   w_last_byte;
    logic              w_reject;
    logic              w_store_ok;
    logic [DATA_W-1:0] w_d_rdata;
    logic              w_if_err_unused;

    assign w_if_gnt = !reset && bus.if_req && (!bus.d_req || r_last_grant == GNT_D);
    assign w_d_gnt  = !reset && bus.d_req && (!bus.if_req || r_last_grant == GNT_IF);

    // One extra address bit catches accesses that would wrap past the top.
    assign w_bytes     = bus.d_we ? size_bytes(bus.d_size) : 4'd8;
    assign w_last_byte = {1'b0, bus.d_addr} + (ADDR_W+1)'(w_bytes) - (ADDR_W+1)'(1);
    assign w_reject    = (bus.d_we && bus.d_size == 2'b00) || w_last_byte[ADDR_W];
    assign w_store_ok  = w_d_gnt && bus.d_we && !w_reject;
    assign w_d_rdata   = (bus.d_we || w_reject) ? '0 : bus.ram_q;

    assign bus.if_ready = w_if_gnt;
    assign bus.d_ready  = w_d_gnt;

    always_comb begin
        bus.ram_load = w_store_ok;
        bus.ram_wr   = w_store_ok ? bus.d_size : 2'b00;
        bus.ram_addr = r_ram_addr;
        bus.ram_d    = r_ram_d;
        if (w_if_gnt) bus.ram_addr = bus.if_addr;
        if (w_d_gnt)  bus.ram_addr = bus.d_addr;
        if (w_store_ok) bus.ram_d = bus.d_wdata;
        if (reset) begin
            bus.ram_addr = '0;
            bus.ram_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= GNT_D;
            r_ram_addr   <= '0;
            r_ram_d      <= '0;
        end else begin
            if (w_if_gnt) r_last_grant <= GNT_IF;
            if (w_d_gnt)  r_last_grant <= GNT_D;
            r_ram_addr <= bus.ram_addr;
            r_ram_d    <= bus.ram_d;
        end
    end

    mem_resp_reg #(.DATA_W(DATA_W)) u_if_resp (
        .clk     (clk),
        .reset   (reset),
        .i_gnt   (w_if_gnt),
        .i_rdata (bus.ram_q),
        .i_err   (1'b0),
        .o_valid (bus.if_valid),
        .o_rdata (bus.if_rdata),
        .o_err   (w_if_err_unused)
    );

    mem_resp_reg #(.DATA_W(DATA_W)) u_d_resp (
        .clk     (clk),
        .reset   (reset),
        .i_gnt   (w_d_gnt),
        .i_rdata (w_d_rdata),
        .i_err   (w_reject),
        .o_valid (bus.d_valid),
        .o_rdata (bus.d_rdata),
        .o_err   (bus.d_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed bench for mem_arbiter with a byte-level reference model
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] sz);
        case (sz)
            2'b01:   return 1;
            2'b10:   return 4;
            2'b11:   return 8;
            default: return 0;
        endcase
    endfunction

    function automatic bit rejected(input logic we, input logic [1:0] sz, input logic [15:0] a);
        int n;
        n = we ? nb(sz) : 8;
        if (we && n == 0) return 1'b1;
        return (int'(a) + n - 1) > 65535;
    endfunction

    // RAM the DUT drives, and an independent shadow the model updates.
    logic [7:0] ram_mem [0:65535];
    logic [7:0] shadow  [0:65535];

    always_comb begin
        bus.ram_q = '0;
        for (int k = 0; k < 8; k++)
            bus.ram_q[8*k +: 8] = ram_mem[16'(bus.ram_addr + 16'(k))];
    end

    always @(posedge clk) begin
        if (bus.ram_load)
            for (int k = 0; k < nb(bus.ram_wr); k++)
                ram_mem[16'(bus.ram_addr + 16'(k))] <= bus.ram_d[8*k +: 8];
    end

    function automatic logic [63:0] rd8(input logic [15:0] a);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = shadow[16'(a + 16'(k))];
        return v;
    endfunction

    // Model state.
    bit          m_last = 1'b1;
    bit          m_if_pend, m_d_pend, m_d_err, m_if_chk;
    logic [63:0] m_if_data, m_d_data;
    logic [15:0] m_ram_addr = '0;
    bit          g_if, g_d, s_we, s_rej;
    logic [1:0]  s_size;
    logic [15:0] s_if_addr, s_d_addr;
    logic [63:0] s_wdata;

    always @(negedge clk) begin
        bit          eg_if, eg_d, st_ok;
        logic [15:0] ea;
        eg_if = !reset && bus.if_req && (!bus.d_req || m_last);
        eg_d  = !reset && bus.d_req && (!bus.if_req || !m_last);
        st_ok = eg_d && bus.d_we && !rejected(bus.d_we, bus.d_size, bus.d_addr);
        check("if_ready", 64'(bus.if_ready), 64'(eg_if));
        check("d_ready", 64'(bus.d_ready), 64'(eg_d));
        check("ram_load", 64'(bus.ram_load), 64'(st_ok));
        check("ram_wr", 64'(bus.ram_wr), st_ok ? 64'(bus.d_size) : 64'd0);
        ea = reset ? 16'd0 : eg_d ? bus.d_addr : eg_if ? bus.if_addr : m_ram_addr;
        check("ram_addr", 64'(bus.ram_addr), 64'(ea));
        if (st_ok) check("ram_d", bus.ram_d, bus.d_wdata);
        check("if_valid", 64'(bus.if_valid), 64'(m_if_pend && !reset));
        check("d_valid", 64'(bus.d_valid), 64'(m_d_pend && !reset));
        if (m_if_pend && !reset && m_if_chk) check("if_rdata", bus.if_rdata, m_if_data);
        if (m_d_pend && !reset) begin
            check("d_err", 64'(bus.d_err), 64'(m_d_err));
            if (!m_d_err) check("d_rdata", bus.d_rdata, m_d_data);
        end
        g_if = eg_if; g_d = eg_d;
        s_if_addr = bus.if_addr; s_d_addr = bus.d_addr; s_we = bus.d_we;
        s_size = bus.d_size; s_wdata = bus.d_wdata;
        s_rej = rejected(bus.d_we, bus.d_size, bus.d_addr);
    end

    always @(posedge clk) begin
        if (reset) begin
            m_last = 1'b1; m_if_pend = 1'b0; m_d_pend = 1'b0; m_ram_addr = '0;
        end else begin
            m_if_pend = g_if;
            m_d_pend  = g_d;
            if (g_if) begin
                m_last = 1'b0; m_ram_addr = s_if_addr;
                m_if_data = rd8(s_if_addr);
                m_if_chk  = s_if_addr <= 16'hFFF8;
            end
            if (g_d) begin
                m_last = 1'b1; m_ram_addr = s_d_addr; m_d_err = s_rej;
                m_d_data = (s_we || s_rej) ? 64'd0 : rd8(s_d_addr);
                if (s_we && !s_rej)
                    for (int k = 0; k < nb(s_size); k++)
                        shadow[16'(s_d_addr + 16'(k))] = s_wdata[8*k +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_issue(input logic we, input logic [1:0] sz, input logic [15:0] a,
                           input logic [63:0] wd);
        int n;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_size = sz; bus.d_addr = a; bus.d_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!bus.d_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!bus.d_ready) begin
            checks++; errors++;
            $display("FAIL d_grant_wait: no grant after %0d cycles, expected a grant", n);
        end
        tick();
        bus.d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit gi, gd;
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = 8'(i * 7 + 65);
            shadow[i]  = 8'(i * 7 + 65);
        end
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_size = 2'b00; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
        check("rst_ram_d", bus.ram_d, 64'd0);
        check("rst_if_rdata", bus.if_rdata, 64'd0);
        check("rst_d_rdata", bus.d_rdata, 64'd0);
        tick();
        reset = 1'b0;

        // Conflict every cycle: fetch first, then alternate.
        bus.if_req = 1; bus.if_addr = 16'h0020;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0040;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("conflict_if_%0d", i), 64'(bus.if_ready), 64'(i % 2 == 0));
            check($sformatf("conflict_d_%0d", i), 64'(bus.d_ready), 64'(i % 2 == 1));
            tick();
        end
        bus.if_req = 0; bus.d_req = 0;
        tick();

        // Fetch of address 0.
        bus.if_req = 1; bus.if_addr = 16'h0000;
        @(negedge clk);
        check("fetch0_ready", 64'(bus.if_ready), 64'd1);
        tick();
        bus.if_req = 0;
        @(negedge clk);
        check("fetch0_valid", 64'(bus.if_valid), 64'd1);
        check("fetch0_byte", 64'(bus.if_rdata[7:0]), 64'd65);
        tick();

        // Word store then load of the same bytes.
        d_issue(1'b1, 2'b10, 16'h0100, 64'hDEADBEEF);
        d_issue(1'b0, 2'b00, 16'h0100, 64'd0);
        @(negedge clk);
        check("ld100_word", 64'(bus.d_rdata[31:0]), 64'hDEADBEEF);
        check("ld100_err", 64'(bus.d_err), 64'd0);
        tick();

        // Double store crossing the top is rejected; load at FFF8 is fine.
        d_issue(1'b1, 2'b11, 16'hFFFA, 64'h0102030405060708);
        @(negedge clk);
        check("stFFFA_valid", 64'(bus.d_valid), 64'd1);
        check("stFFFA_err", 64'(bus.d_err), 64'd1);
        tick();
        d_issue(1'b0, 2'b00, 16'hFFF8, 64'd0);
        @(negedge clk);
        check("ldFFF8_err", 64'(bus.d_err), 64'd0);
        tick();

        // Size-00 store rejected; byte store at the last address accepted.
        d_issue(1'b1, 2'b00, 16'h0200, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check("st00_err", 64'(bus.d_err), 64'd1);
        tick();
        d_issue(1'b1, 2'b01, 16'hFFFF, 64'h00000000000000A5);
        @(negedge clk);
        check("stFFFF_err", 64'(bus.d_err), 64'd0);
        tick();
        d_issue(1'b0, 2'b00, 16'hFFF8, 64'd0);
        @(negedge clk);
        check("ldFFF8_top", 64'(bus.d_rdata[63:56]), 64'hA5);
        tick();
        d_issue(1'b0, 2'b00, 16'h0200, 64'd0);
        tick();

        // Reset while a fetch response is pending; store during reset is dropped.
        bus.if_req = 1; bus.if_addr = 16'h0030;
        @(negedge clk);
        check("prerst_ready", 64'(bus.if_ready), 64'd1);
        tick();
        bus.if_req = 0; reset = 1'b1;
        bus.d_req = 1; bus.d_we = 1; bus.d_size = 2'b11; bus.d_addr = 16'h0300;
        bus.d_wdata = 64'h1122334455667788;
        @(negedge clk);
        check("rst_drop_valid", 64'(bus.if_valid), 64'd0);
        tick();
        reset = 1'b0; bus.d_req = 0;
        bus.if_req = 1; bus.if_addr = 16'h0038;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0300;
        @(negedge clk);
        check("postrst_if_wins", 64'(bus.if_ready), 64'd1);
        tick();
        bus.if_req = 0;
        @(negedge clk);
        check("postrst_no_write", 64'(bus.if_valid && shadow[16'h0300] == 8'(16'h0300 * 7 + 65)), 64'd1);
        tick();
        bus.d_req = 0;
        tick();

        // Mixed traffic honouring the hold-until-ready rule.
        gi = 0; gd = 0;
        for (int c = 0; c < 40; c++) begin
            if (!bus.if_req || gi) begin
                bus.if_req  = (c % 3 != 2);
                bus.if_addr = 16'((c * 24) % 16'h0800);
            end
            if (!bus.d_req || gd) begin
                bus.d_req   = (c % 4 != 3);
                bus.d_we    = (c % 5 < 2);
                bus.d_size  = 2'(c % 4);
                bus.d_addr  = (c % 7 == 0) ? 16'hFFFC : 16'(16'h0400 + (c * 13) % 16'h0200);
                bus.d_wdata = {32'(c), 32'hC0DE0000 + 32'(c)};
            end
            @(negedge clk);
            gi = bus.if_ready; gd = bus.d_ready;
            tick();
        end
        bus.if_req = 0; bus.d_req = 0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
